// File: rtl/equiv_chk_pkg.sv
// Shared types, constants and the MISR step function for the output
// equivalence checker (golden vs synthesized instance comparison).
package equiv_chk_pkg;

  // Default width of the compared output vector (the fuzz top's y).
  localparam int Y_W_DEFAULT = 82;

  // MISR feedback polynomial and seed value.
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  // Checker run states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } chk_state_e;

  // One MISR step: shift left, apply feedback when the MSB falls out,
  // then absorb the folded data word.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] fold);
    logic [31:0] fb;
    fb = sig[31] ? MISR_POLY : 32'h0000_0000;
    return {sig[30:0], 1'b0} ^ fb ^ fold;
  endfunction

endpackage

// File: rtl/equiv_misr.sv
// 32-bit MISR over a Y_W-bit data word. The word is cut into 32-bit
// slices (top slice zero-padded) that are XOR-folded into one word per step.
module equiv_misr
  import equiv_chk_pkg::*;
#(
  parameter int Y_W = Y_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           en,
  input  logic [Y_W-1:0] data,
  output logic [31:0]    sig
);

  localparam int NSLICE = (Y_W + 31) / 32;

  logic [NSLICE*32-1:0] w_pad;
  logic [31:0]          w_fold;
  logic [31:0]          r_sig;

  // Zero-pad the data word and XOR-fold its 32-bit slices
  always_comb begin
    w_pad          = {(NSLICE*32){1'b0}};
    w_pad[Y_W-1:0] = data;
    w_fold         = 32'h0000_0000;
    for (int i = 0; i < NSLICE; i++) begin
      w_fold = w_fold ^ w_pad[i*32 +: 32];
    end
  end

  // Signature register: seed on reset or load, step on enable, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= MISR_SEED;
    end else if (load) begin
      r_sig <= MISR_SEED;
    end else if (en) begin
      r_sig <= misr_step(r_sig, w_fold);
    end else begin
      r_sig <= r_sig;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/equiv_out_checker.sv
// Output equivalence checker: discards WARMUP valid samples, then compares
// y_ref against y_dut for num_cycles valid samples, latching the first
// mismatch (index and XOR pattern).
// Optional feature macro EQUIV_CHK_MISR_EN: when defined a MISR signature
// over y_dut is built; when undefined signature is tied to zero.
module equiv_out_checker
  import equiv_chk_pkg::*;
#(
  parameter int Y_W    = Y_W_DEFAULT,
  parameter int CNT_W  = 16,
  parameter int WARMUP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             y_valid,
  input  logic [Y_W-1:0]   y_ref,
  input  logic [Y_W-1:0]   y_dut,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] fail_cycle,
  output logic [Y_W-1:0]   fail_xor,
  output logic [31:0]      signature
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  chk_state_e       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_fail_cycle;
  logic [Y_W-1:0]   r_fail_xor;

  logic             w_start_ok;
  logic             w_cmp_en;
  logic [Y_W-1:0]   w_xor;

  // Start acceptance, per-sample compare strobe and difference pattern
  always_comb begin
    w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_cmp_en   = (r_state == ST_COMPARE) && y_valid && (r_num != CNT_ZERO);
    w_xor      = y_ref ^ y_dut;
  end

  // Run-control FSM with registered busy/done decodes and first-fail capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_num        <= CNT_ZERO;
      r_wcnt       <= CNT_ZERO;
      r_idx        <= CNT_ZERO;
      r_fail_cycle <= CNT_ZERO;
      r_fail_xor   <= {Y_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_num        <= num_cycles;
            r_wcnt       <= CNT_ZERO;
            r_idx        <= CNT_ZERO;
            r_mismatch   <= 1'b0;
            r_fail_cycle <= CNT_ZERO;
            r_fail_xor   <= {Y_W{1'b0}};
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            if (WARMUP == 0) begin
              r_state <= ST_COMPARE;
            end else begin
              r_state <= ST_WARMUP;
            end
          end
        end
        ST_WARMUP: begin
          // Settling samples are only counted, never compared
          if (y_valid) begin
            r_wcnt <= r_wcnt + CNT_ONE;
            if (r_wcnt == CNT_W'(WARMUP - 1)) begin
              r_state <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (r_num == CNT_ZERO) begin
            // Empty window: finish immediately without comparing
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_cmp_en) begin
            // Only the first inequality is recorded; the window keeps running
            if ((w_xor != {Y_W{1'b0}}) && !r_mismatch) begin
              r_mismatch   <= 1'b1;
              r_fail_cycle <= r_idx;
              r_fail_xor   <= w_xor;
            end
            r_idx <= r_idx + CNT_ONE;
            if (r_idx == (r_num - CNT_ONE)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign mismatch   = r_mismatch;
  assign fail_cycle = r_fail_cycle;
  assign fail_xor   = r_fail_xor;

`ifdef EQUIV_CHK_MISR_EN
  equiv_misr #(
    .Y_W (Y_W)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (w_start_ok),
    .en   (w_cmp_en),
    .data (y_dut),
    .sig  (signature)
  );
`else
  assign signature = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_equiv_out_checker.sv
// Self-checking bench for equiv_out_checker: random sample streams with
// directed mismatches, checked against a behavioural model of the window.
module tb_equiv_out_checker;

  localparam int WARM = 2;

`ifdef EQUIV_CHK_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_cycles = 16'd0;
  logic        y_valid = 1'b0;
  logic [81:0] y_ref = 82'd0;
  logic [81:0] y_dut = 82'd0;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [15:0] fail_cycle;
  logic [81:0] fail_xor;
  logic [31:0] signature;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [81:0] s_ref[$];
  logic [81:0] s_dut[$];

  equiv_out_checker #(
    .Y_W    (82),
    .CNT_W  (16),
    .WARMUP (WARM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .y_valid    (y_valid),
    .y_ref      (y_ref),
    .y_dut      (y_dut),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .fail_cycle (fail_cycle),
    .fail_xor   (fail_xor),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  function automatic logic [81:0] rand82();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[81:0];
  endfunction

  task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Build an identical random stream: WARM settling samples + compare window
  task automatic fill(input int n);
    int tot;
    tot = WARM + ((n == 0) ? 1 : n);
    s_ref.delete();
    s_dut.delete();
    for (int i = 0; i < tot; i++) begin
      s_ref.push_back(rand82());
      s_dut.push_back(s_ref[i]);
    end
  endtask

  // Expected results of a window of n compared samples
  task automatic model(input int n, output logic exp_mm, output logic [15:0] exp_fc,
                       output logic [81:0] exp_fx, output logic [31:0] exp_sig);
    logic [81:0] y;
    logic [31:0] fold;
    logic        msb;
    exp_mm  = 1'b0;
    exp_fc  = 16'd0;
    exp_fx  = 82'd0;
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      if (!exp_mm && (s_ref[WARM+i] != s_dut[WARM+i])) begin
        exp_mm = 1'b1;
        exp_fc = 16'(i);
        exp_fx = s_ref[WARM+i] ^ s_dut[WARM+i];
      end
      y    = s_dut[WARM+i];
      fold = y[31:0] ^ y[63:32] ^ {14'd0, y[81:64]};
      msb  = exp_sig[31];
      exp_sig = {exp_sig[30:0], 1'b0};
      if (msb) exp_sig = exp_sig ^ 32'h04C11DB7;
      exp_sig = exp_sig ^ fold;
    end
    if (!MISR_ON) exp_sig = 32'h0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 82'(busy), 82'd0);
    chk({tag, "_done"}, 82'(done), 82'd0);
    chk({tag, "_mm"},   82'(mismatch), 82'd0);
    chk({tag, "_fc"},   82'(fail_cycle), 82'd0);
    chk({tag, "_fx"},   fail_xor, 82'd0);
    chk({tag, "_sig"},  82'(signature), MISR_ON ? 82'hFFFFFFFF : 82'd0);
  endtask

  // One full run from start to done; start_at >= 0 re-pulses start on that sample
  task automatic run_case(input string tag, input int n, input int max_gap, input int start_at);
    logic        e_mm;
    logic [15:0] e_fc;
    logic [81:0] e_fx;
    logic [31:0] e_sig;
    int          nfeed;
    int          gaps;
    nfeed = WARM + ((n == 0) ? 1 : n);
    model(n, e_mm, e_fc, e_fx, e_sig);
    @(negedge clk);
    start = 1'b1;
    num_cycles = 16'(n);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_run"}, 82'(busy), 82'd1);
    for (int k = 0; k < nfeed; k++) begin
      gaps = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gaps; g++) begin
        y_valid = 1'b0;
        y_ref = rand82();
        y_dut = rand82();
        @(negedge clk);
      end
      y_valid = 1'b1;
      y_ref = s_ref[k];
      y_dut = s_dut[k];
      if (k == start_at) begin
        start = 1'b1;
        num_cycles = 16'd3;
      end
      if (k == nfeed - 1) chk({tag, "_done_early"}, 82'(done), 82'd0);
      @(negedge clk);
      start = 1'b0;
    end
    y_valid = 1'b0;
    chk({tag, "_done"}, 82'(done), 82'd1);
    chk({tag, "_busy_end"}, 82'(busy), 82'd0);
    chk({tag, "_mm"}, 82'(mismatch), 82'(e_mm));
    chk({tag, "_fc"}, 82'(fail_cycle), 82'(e_fc));
    chk({tag, "_fx"}, fail_xor, e_fx);
    chk({tag, "_sig"}, 82'(signature), 82'(e_sig));
    // DONE holds its results while unequal valid samples keep arriving
    for (int i = 0; i < 2; i++) begin
      y_valid = 1'b1;
      y_ref = rand82();
      y_dut = ~y_ref;
      @(negedge clk);
    end
    y_valid = 1'b0;
    chk({tag, "_hold_done"}, 82'(done), 82'd1);
    chk({tag, "_hold_mm"}, 82'(mismatch), 82'(e_mm));
    chk({tag, "_hold_sig"}, 82'(signature), 82'(e_sig));
  endtask

  initial begin
    // Reset state, while asserted and after release
    repeat (3) @(negedge clk);
    chk_idle("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_rel");

    // Identical streams, 8-sample window
    fill(8);
    run_case("ident", 8, 0, -1);

    // Single mismatch: bit 81 flipped at compare index 3
    fill(8);
    s_dut[WARM+3] = s_ref[WARM+3] ^ (82'd1 << 81);
    run_case("single", 8, 0, -1);
    chk("single_fx_const", fail_xor, 82'd1 << 81);
    chk("single_fc_const", 82'(fail_cycle), 82'd3);

    // Multiple mismatches at 2 and 5, with a start pulse mid-compare (ignored)
    fill(8);
    s_dut[WARM+2] = s_ref[WARM+2] ^ (rand82() | 82'd1);
    s_dut[WARM+5] = s_ref[WARM+5] ^ (rand82() | 82'd4);
    run_case("multi", 8, 0, WARM + 4);
    chk("multi_fc_const", 82'(fail_cycle), 82'd2);

    // Same stream with random y_valid gaps gives the same result
    run_case("gaps", 8, 3, -1);

    // Empty window: a mismatching valid in COMPARE must not be compared
    fill(0);
    s_dut[WARM] = ~s_ref[WARM];
    run_case("empty", 0, 0, -1);

    // Reset mid-run at compare index 4, after a mismatch at index 1
    fill(8);
    s_dut[WARM+1] = ~s_ref[WARM+1];
    @(negedge clk);
    start = 1'b1;
    num_cycles = 16'd8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < WARM + 4; k++) begin
      y_valid = 1'b1;
      y_ref = s_ref[k];
      y_dut = s_dut[k];
      @(negedge clk);
    end
    chk("midrst_pre_mm", 82'(mismatch), 82'd1);
    chk("midrst_pre_busy", 82'(busy), 82'd1);
    y_ref = s_ref[WARM+4];
    y_dut = s_dut[WARM+4];
    rst = 1'b1;
    #1;
    chk_idle("midrst_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y_valid = 1'b1;
      y_ref = rand82();
      y_dut = ~y_ref;
      @(negedge clk);
    end
    y_valid = 1'b0;
    chk_idle("midrst_after");

    // Recovery run after the abort
    fill(5);
    s_dut[WARM+4] = s_ref[WARM+4] ^ (82'd1 << 40);
    run_case("recover", 5, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/equiv_out_checker.md
EQUIV_OUT_CHECKER -- requirements
Module: equiv_out_checker

Interface
REQ-001 Parameter Y_W, default 82: width of the compared output vector, matching the 82-bit `y` of the fuzz top.
REQ-002 Parameter CNT_W, default 16: width of the sample counters and of `num_cycles`.
REQ-003 Parameter WARMUP, default 2: number of valid samples discarded before comparison starts, covering register init settling.
REQ-004 Port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port `start`, input, 1 bit: begins a check run; sampled only in IDLE or DONE.
REQ-007 Port `num_cycles`, input, CNT_W bits: number of samples to compare; captured on an accepted `start`.
REQ-008 Port `y_valid`, input, 1 bit: `y_ref` and `y_dut` are valid this cycle.
REQ-009 Port `y_ref`, input, Y_W bits: output of the golden (pre-synthesis) instance.
REQ-010 Port `y_dut`, input, Y_W bits: output of the synthesized instance.
REQ-011 Port `busy`, output, 1 bit: high in WARMUP and COMPARE.
REQ-012 Port `done`, output, 1 bit: high in DONE.
REQ-013 Port `mismatch`, output, 1 bit: sticky flag set by any compared inequality.
REQ-014 Port `fail_cycle`, output, CNT_W bits: compare index of the first mismatch.
REQ-015 Port `fail_xor`, output, Y_W bits: `y_ref ^ y_dut` at the first mismatch.
REQ-016 Port `signature`, output, 32 bits: MISR signature over `y_dut`.

Function
REQ-017 The FSM SHALL have states IDLE, WARMUP, COMPARE and DONE; `busy` and `done` are registered decodes of the state.
REQ-018 On `start` in IDLE or DONE, the block SHALL:
- go to WARMUP, or directly to COMPARE when WARMUP=0;
- capture `num_cycles`;
- clear `mismatch`, `fail_cycle`, `fail_xor` and both counters;
- load `signature` with 32'hFFFFFFFF.
REQ-019 `start` in WARMUP or COMPARE SHALL be ignored.
REQ-020 In WARMUP, each `y_valid` SHALL increment the warmup counter; the valid on which the counter reaches WARMUP-1 SHALL move the FSM to COMPARE. No comparison or MISR update is made in WARMUP.
REQ-021 In COMPARE, each `y_valid` cycle SHALL compare `y_ref` with `y_dut`, update the MISR, and then increment the compare index.
REQ-022 The first inequality SHALL set `mismatch`, capture the current index into `fail_cycle` and capture the XOR into `fail_xor`; later mismatches SHALL NOT overwrite the captured values.
REQ-023 Comparison SHALL continue after a mismatch until the window ends, so that `signature` always covers the full window.
REQ-024 The valid sample with index `num_cycles`-1 SHALL move the FSM to DONE; `done` rises on the next clock edge (1-cycle latency).
REQ-025 When the captured `num_cycles` is 0, COMPARE SHALL go to DONE on the first clock edge with no compare and no MISR update; `mismatch` stays 0.
REQ-026 Cycles with `y_valid` low SHALL NOT advance any counter, compare, or MISR.
REQ-027 DONE SHALL hold all outputs until the next accepted `start`.
REQ-028 MISR update: `fold` is the XOR of the 32-bit slices of `y_dut`, with the top slice zero-padded. Then sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.

Reset
REQ-029 Asserting `rst` SHALL asynchronously force:
- state to IDLE;
- `busy`, `done`, `mismatch` to 0;
- `fail_cycle`, `fail_xor` to 0;
- `signature` to 32'hFFFFFFFF.
REQ-030 `rst` asserted during WARMUP or COMPARE SHALL abort the run with no `done` pulse; a new `start` is required after release.

Configuration
REQ-031 Macro EQUIV_CHK_MISR_EN:
- When defined, the MISR is built and `signature` behaves per REQ-028.
- When undefined, no MISR logic is built and `signature` is tied to 32'h0.
- All other behaviour is identical in both builds.

Structure
REQ-032 Package `equiv_chk_pkg` SHALL hold:
- the state typedef;
- MISR_POLY = 32'h04C11DB7;
- MISR_SEED = 32'hFFFFFFFF;
- the default Y_W = 82.
REQ-033 The MISR SHALL be a sub-module `equiv_misr`, with ports: `clk`, `rst`, `load`, `en`, data (Y_W bits) and `sig`.

Verification
REQ-034 Identical streams test: WARMUP=2, num_cycles=8, 10 valid cycles with `y_ref` == `y_dut` -> `done`=1 one cycle after the 10th valid, `mismatch`=0.
REQ-035 Single mismatch test: bit 81 of `y_dut` flipped at compare index 3 -> `mismatch`=1, `fail_cycle`=3, `fail_xor`=82'h1 << 81.
REQ-036 Multiple mismatch test: mismatches at indices 2 and 5 -> `fail_cycle`=2, and `signature` equals the model MISR over all 8 samples.
REQ-037 Empty window and gap test:
- num_cycles=0 -> `done` without any compare;
- `y_valid` gaps in the stream -> same result as the same stream without gaps.
REQ-038 Reset mid-run test: `rst` pulsed at compare index 4 -> IDLE with all outputs at reset values; `start` asserted during COMPARE -> ignored.
